// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the FIFO-fed UART transmitter.
//   uart_state_e    : transmitter FSM encoding
//   DATA_BITS       : data bits per UART character (8N1)
//   STOP_BITS       : stop bits per character
//   BYTES_PER_WORD  : bytes carried by one 16-bit FIFO word
//   WAIT_CYCLES     : cycles spent waiting for the FIFO read data
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_START = 3'd4,
    ST_DATA  = 3'd5,
    ST_STOP  = 3'd6
  } uart_state_e;

  localparam int DATA_BITS      = 8;
  localparam int STOP_BITS      = 1;
  localparam int BYTES_PER_WORD = 2;
  localparam int WAIT_CYCLES    = 2;

  // True while the FSM is putting a character on the line (bit timer runs).
  function automatic logic on_line(input uart_state_e s);
    return (s == ST_START) || (s == ST_DATA) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period generator.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   start : level; held high while bits are being sent, low clears the count
//   tick  : one-cycle pulse in the last cycle of every CLKS_PER_BIT period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrapping to zero on the tick cycle keeps consecutive bits exactly
  // CLKS_PER_BIT long with no accumulated drift.
  always_comb begin
    cnt_d = cnt_q;
    if (!start || (cnt_q == LAST)) cnt_d = '0;
    else                           cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = start && (cnt_q == LAST);

endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pulls 16-bit words from a FIFO and sends each as two 8N1
// characters, low byte first.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : transmit enable (level), sampled only in IDLE
//   fifo_empty   : FIFO empty flag
//   fifo_data    : FIFO registered read data
//   fifo_rd_req  : one-cycle read request per word (FIFO is edge-triggered)
//   tx           : serial line, idle high, registered
//   busy         : high whenever the FSM is not in IDLE
//   word_done    : one-cycle pulse in the IDLE cycle that ends a word
//   dbg_state    : current FSM state
// Handshake: a word is requested only when en=1 and fifo_empty=0 in IDLE;
// fifo_rd_req rises for exactly one cycle, the data is taken two WAIT cycles
// later, and nothing from the FIFO side can cancel a word once requested.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_req,
  output logic                  tx,
  output logic                  busy,
  output logic                  word_done,
  output uart_state_e           dbg_state
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e           state_q, state_d;
  logic                  armed_q;
  logic                  wait_q, wait_d;
  logic                  byte_sel_q, byte_sel_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  rd_req_q, rd_req_d;
  logic                  done_q, done_d;
  logic                  tick;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (on_line(state_q)),
    .tick  (tick)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // armed_q keeps the first request off the first edge after reset.
      ST_IDLE:  if (armed_q && en && !fifo_empty) state_d = ST_REQ;
      ST_REQ:   state_d = ST_WAIT;
      ST_WAIT:  if (wait_q) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA:  if (tick && (bit_idx_q == LAST_BIT)) state_d = ST_STOP;
      ST_STOP:  if (tick) state_d = byte_sel_q ? ST_IDLE : ST_START;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    // WAIT_CYCLES is 2, so a single toggle bit marks the second WAIT cycle.
    wait_d     = (state_q == ST_WAIT) ? !wait_q : 1'b0;
    byte_sel_d = byte_sel_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;

    if (state_q == ST_LOAD) begin
      shift_d    = fifo_data;
      byte_sel_d = 1'b0;
    end
    // Shifting across all 16 bits leaves the high byte in [7:0] once the
    // low byte has gone out, so shift_q[0] is always the current bit.
    if ((state_q == ST_DATA) && tick) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = (bit_idx_q == LAST_BIT) ? 3'd0 : bit_idx_q + 3'd1;
    end
    if ((state_q == ST_STOP) && tick && !byte_sel_q) byte_sel_d = 1'b1;

    // Registered outputs are computed from the next state so they line up
    // with the state register.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d   = (state_d != ST_IDLE);
    rd_req_d = (state_d == ST_REQ);
    done_d   = (state_q == ST_STOP) && tick && byte_sel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      wait_q     <= 1'b0;
      byte_sel_q <= 1'b0;
      bit_idx_q  <= 3'd0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rd_req_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      wait_q     <= wait_d;
      byte_sel_q <= byte_sel_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rd_req_q   <= rd_req_d;
      done_q     <= done_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign fifo_rd_req = rd_req_q;
  assign word_done   = done_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, FIFO word width; fixed at 16 (two bytes per word).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  transmit enable, level.
REQ-006 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  16  FIFO registered read data.
REQ-008 SHALL have port fifo_rd_req  output  1  FIFO read request; the FIFO reacts to its rising edge only.
REQ-009 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port word_done  output  1  one-cycle pulse at the end of a word's second stop bit.

Function
REQ-012 SHALL implement states IDLE, REQ, WAIT, LOAD, START, DATA, STOP.
REQ-013 IDLE: tx=1; when en=1 and fifo_empty=0 at a clock edge, SHALL go to REQ; otherwise stay.
REQ-014 REQ: fifo_rd_req=1 for exactly one cycle, then WAIT; fifo_rd_req SHALL be 0 in all other states, guaranteeing a fresh rising edge per word.
REQ-015 WAIT: SHALL last exactly 2 cycles, covering FIFO edge-detect plus registered-output latency, then LOAD.
REQ-016 LOAD: SHALL capture fifo_data into a 16-bit shift register, clear byte_sel to 0, go to START; total overhead from REQ entry to START entry is 4 cycles.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles; byte_sel=0 sends word[7:0], byte_sel=1 sends word[15:8]; then STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles; if byte_sel=0, SHALL set byte_sel=1 and go directly to START (no idle gap between bytes); if byte_sel=1, SHALL pulse word_done and go to IDLE.
REQ-020 One word SHALL occupy exactly 20*CLKS_PER_BIT cycles from START entry to IDLE entry.
REQ-021 en deasserted mid-word SHALL NOT abort; the current word completes, then the block stays in IDLE.
REQ-022 fifo_empty rising during REQ/WAIT SHALL be ignored; the word is loaded regardless, since empty was checked in IDLE.
REQ-023 Back-to-back words SHALL have exactly one IDLE cycle between word_done and the next REQ entry.
REQ-024 Bit-time counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and reload to 0 on each bit boundary without drift.
REQ-025 tx SHALL be driven from a register (glitch-free).

Reset
REQ-026 On rst=1, SHALL immediately force: state=IDLE, tx=1, busy=0, fifo_rd_req=0, word_done=0, shift register=0, byte_sel=0, bit counter=0, bit index=0.
REQ-027 Reset mid-frame SHALL abort the frame with no partial stop bit; after release, the first REQ SHALL NOT occur before the second clock edge.

Structure
REQ-028 State encoding and the UART constants (8 data bits, 1 stop bit, 2 bytes per word) SHALL reside in shared package uart_pkg.
REQ-029 Bit timing SHALL be a sub-module uart_bit_timer (clk, rst, start, tick) producing a one-cycle tick every CLKS_PER_BIT cycles while running.

Verification (CLKS_PER_BIT=4, bench FIFO model with edge-detected read)
REQ-030 Single word: load 0xA55A, set en=1 -> fifo_rd_req pulses once; tx frames are 0,0x5A LSB-first,1 then 0,0xA5 LSB-first,1; word_done at cycle 80 after START entry.
REQ-031 Empty FIFO: en=1 with fifo_empty=1 for 200 cycles -> fifo_rd_req never rises; tx=1; busy=0.
REQ-032 Back-to-back: load 0x0001 and 0x8000 -> two words, 0x01,0x00,0x00,0x80 on the line; exactly one IDLE cycle between words; two rd_req edges.
REQ-033 en drop: deassert en during first DATA bit of 0x1234 -> both bytes 0x34,0x12 complete; no further fifo_rd_req.
REQ-034 Reset mid-frame: assert rst during DATA of byte 0 -> tx=1 and busy=0 in the same cycle; after release with FIFO non-empty, a clean new word starts with START.
REQ-035 Timing check: measure every bit period across 10 words -> all exactly 4 cycles; START-to-START of byte 1 equals 40 cycles.
